regfile_write_arbiter: RTL

- Shares the single write port of the 32x32 register file among N_REQ writeback requesters (e.g. ALU result, load return, link/JAL).
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives the register file's write, write_reg and write_data inputs from a registered output stage.
- Enforces the MIPS rule that register 0 is never written; all regfile writes in the design pass through this block.

---
 rtl/regfile_write_arbiter_pkg.sv | 22 ++
 rtl/regfile_write_arbiter_if.sv | 33 +++
 rtl/regfile_write_arbiter_rr_arbiter.sv | 41 ++++
 rtl/regfile_write_arbiter.sv | 66 ++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write path.
// Holds the register file geometry, the hard-wired zero register index,
// the writeback requester ID encoding and a one-hot decode helper.
package regfile_write_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_COUNT  = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        REQ_ALU  = 2'd0,
        REQ_MEM  = 2'd1,
        REQ_LINK = 2'd2
    } req_id_e;

    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
        return REG_COUNT'(1) << idx;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the requesters and the write arbiter, plus the
// arbiter's registered drive toward the register file.
//   req_valid/req_reg/req_data : per-requester request, packed by index
//   req_ready                  : one-hot grant (or zero)
//   write/write_reg/write_data : register file write port
//   pending_mask               : one-hot index of the write being presented
// master = requester/regfile side, slave = arbiter.
interface regfile_write_arbiter_if #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    import regfile_write_arbiter_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_reg;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    write;
    logic [ADDR_W-1:0]       write_reg;
    logic [DATA_W-1:0]       write_data;
    logic [REG_COUNT-1:0]    pending_mask;

    modport master (
        output req_valid, req_reg, req_data,
        input  req_ready, write, write_reg, write_data, pending_mask
    );

    modport slave (
        input  req_valid, req_reg, req_data,
        output req_ready, write, write_reg, write_data, pending_mask
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin priority search over N requests.
//   req       : request vector
//   ptr       : highest-priority index this cycle (must be < N)
//   grant     : one-hot grant, zero when no request
//   grant_idx : encoded index of the granted request
module rr_arbiter #(
    parameter  int unsigned N  = 3,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);
    localparam int unsigned DW = $clog2(2 * N);

    // Two copies back to back: scanning from ptr upward through the
    // doubled vector covers the wrap without a modulo in the loop.
    logic [2*N-1:0] dbl;
    logic [DW-1:0]  pos;
    logic           found;

    assign dbl = {req, req};

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = DW'(ptr) + DW'(k);
            if (!found && dbl[pos]) begin
                found     = 1'b1;
                grant_idx = (pos >= DW'(N)) ? PW'(pos - DW'(N)) : PW'(pos);
            end
        end
        if (found) begin
            grant = N'(1) << grant_idx;
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among N_REQ writeback
// requesters with round-robin arbitration and a registered output stage.
// Writes to register 0 are accepted but never reach the register file.
//   cclk : clock, rising edge
//   rst  : asynchronous active-high reset
//   hold : blocks all grants while high
//   bus  : requester handshake and register file write port (slave side)
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                 cclk,
    input  logic                 rst,
    input  logic                 hold,
    regfile_write_arbiter_if.slave bus
);
    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     grant_idx;
    logic [N_REQ-1:0]  grant;
    logic              xfer;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants are masked by rst as well so ready drops the instant reset rises.
    always_comb begin
        bus.req_ready = '0;
        if (!rst && !hold) begin
            bus.req_ready = grant;
        end
    end

    assign xfer     = !hold && (|grant);
    assign sel_reg  = bus.req_reg[grant_idx*ADDR_W +: ADDR_W];
    assign sel_data = bus.req_data[grant_idx*DATA_W +: DATA_W];

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            rr_ptr         <= '0;
            bus.write      <= 1'b0;
            bus.write_reg  <= '0;
            bus.write_data <= '0;
        end else if (xfer) begin
            // Explicit wrap keeps rr_ptr < N_REQ for non-power-of-two counts.
            rr_ptr         <= (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            bus.write_reg  <= sel_reg;
            bus.write_data <= sel_data;
            bus.write      <= (sel_reg != ADDR_W'(REG_ZERO));
        end else begin
            bus.write      <= 1'b0;
        end
    end

    assign bus.pending_mask = bus.write ? reg_onehot(REG_ADDR_W'(bus.write_reg)) : '0;
endmodule
